prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the 4-bit CPU's instruction memory.
- Accepts a framed byte stream from a host over a valid/ready handshake. Each byte is one instruction: opcode in the high nibble, operand in the low nibble.
- Writes each byte as two consecutive 4-bit memory words, pads the unused tail with SLEEP instructions, then verifies an XOR checksum.
- Holds the CPU in reset for the whole load and releases it, with a one-cycle wakeup pulse, only after a clean load.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 4, memory word width (nibble).
- MEM_DEPTH, 16, number of memory words; maximum program length is MEM_DEPTH/2 = 8 instructions.
- SLEEP_OP, 4'b1000, opcode written into padded instruction slots; the operand word of a padded slot is 0.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets the block on the next rising edge).
- start  in  1  begin a load; sampled only in IDLE, DONE or ERR.
- in_data  in  8  host byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- cpu_hold  out  1  high = CPU must be held in reset.
- wakeup  out  1  one-cycle pulse to the CPU on successful completion.
- done  out  1  load complete and checksum correct.
- err  out  1  bad header or checksum mismatch.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, wakeup=0, done=0, err=0, state=IDLE.
- Byte transfer: a byte transfers on any cycle with in_valid && in_ready. in_ready is asserted only in HDR, PAY and CHK.
- Frame format: byte N (instruction count), then N payload bytes, then one checksum byte. The checksum equals the XOR of the N payload bytes; the header is not included.
- IDLE: on start=1 go to HDR. In this transition cycle cpu_hold=1, done=0 and err=0 are set.
- HDR: in_ready=1. When a byte transfers:
  - N==0 or N>MEM_DEPTH/2 → ERR.
  - Otherwise latch N, clear the byte counter k and the running XOR, → PAY.
- PAY: in_ready=1. When a byte transfers, latch it, XOR it into the running checksum, deassert in_ready, → WHI.
- WHI: mem_we=1, mem_addr=2k, mem_wdata=byte[7:4]. → WLO.
- WLO: mem_we=1, mem_addr=2k+1, mem_wdata=byte[3:0]. k increments.
  - If k+1 < N → PAY.
  - Else if 2(k+1) < MEM_DEPTH → PAD.
  - Else → CHK.
- Throughput: minimum 3 cycles per payload byte. in_ready returns high in the cycle after WLO.
- PAD: one write per cycle. Even address gets SLEEP_OP, odd address gets 0. Runs until address MEM_DEPTH-1 has been written, then → CHK.
- CHK: in_ready=1. When a byte transfers:
  - byte == running XOR → DONE.
  - Otherwise → ERR.
- DONE: cpu_hold=0 and done=1. wakeup=1 for exactly the first cycle in DONE.
- ERR: err=1 and cpu_hold stays 1. Memory is not cleared, so it may hold a partial or unchecked program.
- Restart: start=1 in DONE or ERR → HDR. cpu_hold is reasserted in that same cycle and done/err are cleared.
- start while busy: start in HDR, PAY, WHI, WLO, PAD or CHK is ignored.
- mem_we is 0 in every state other than WHI, WLO and PAD. mem_addr and mem_wdata hold their last values when mem_we=0.
- in_valid deasserted mid-frame: the loader waits indefinitely. There is no timeout.
- Reset mid-operation: on the next edge all outputs return to their reset values and the FSM goes to IDLE. Memory already written is left as is.
- Address arithmetic is modulo 2^ADDR_W. With the header check in place, no address ever exceeds MEM_DEPTH-1.

Test Plan:
- Full program:
  - Stimulus: start; bytes 0x08, 0x15, 0x13, 0x20, 0x30, 0x40, 0x50, 0x70, 0x80, then checksum 0xF6.
  - Required: words 0..15 = 1,5,1,3,2,0,3,0,4,0,5,0,7,0,8,0; no PAD writes; done=1; cpu_hold=0; one wakeup pulse.
- Short program:
  - Stimulus: 0x02, 0x15, 0x13, checksum 0x06.
  - Required: words 0..3 = 1,5,1,3; words 4..15 alternate 8,0 (12 PAD writes); done=1.
- Bad checksum:
  - Stimulus: 0x02, 0x15, 0x13, checksum 0x07.
  - Required: err=1; cpu_hold=1; wakeup never pulses; a following start returns to HDR with err=0.
- Bad header:
  - Stimulus: header 0x00, then (after restart) header 0x09.
  - Required: err=1 immediately after each header byte; no mem_we ever asserted.
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly; in_valid held high during WHI/WLO.
  - Required: no byte accepted while in_ready=0; memory contents match the short-program case.
- Reset mid-load:
  - Stimulus: reset=0 after the 3rd memory write of the full program.
  - Required: next edge gives all outputs at reset values, state IDLE; a subsequent full load completes with done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, writes it as nibble pairs
// into the CPU instruction memory, pads with SLEEP, verifies an XOR checksum and wakes the CPU.
module prog_loader #(
   parameter int                ADDR_W    = 4,
   parameter int                DATA_W    = 4,
   parameter int                MEM_DEPTH = 16,
   parameter logic [DATA_W-1:0] SLEEP_OP  = 4'b1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              wakeup,
   output logic              done,
   output logic              err
);

   localparam logic [3:0] IDLE = 4'd0;
   localparam logic [3:0] HDR  = 4'd1;
   localparam logic [3:0] PAY  = 4'd2;
   localparam logic [3:0] WHI  = 4'd3;
   localparam logic [3:0] WLO  = 4'd4;
   localparam logic [3:0] PAD  = 4'd5;
   localparam logic [3:0] CHK  = 4'd6;
   localparam logic [3:0] DONE = 4'd7;
   localparam logic [3:0] ERR  = 4'd8;

   localparam logic [7:0]        MAX_N     = 8'(MEM_DEPTH / 2);
   localparam logic [ADDR_W:0]   HALF      = (ADDR_W + 1)'(MEM_DEPTH / 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   logic [3:0]        state;
   logic [3:0]        state_nxt;
   logic [ADDR_W:0]   n_q;
   logic [ADDR_W-1:0] k_q;
   logic [ADDR_W:0]   k_inc;
   logic [7:0]        byte_q;
   logic [7:0]        sum_q;
   logic              fire;

   assign fire  = in_valid & in_ready;
   assign k_inc = {1'b0, k_q} + (ADDR_W + 1)'(1);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) state_nxt = HDR;
         end
         HDR: begin
            if (fire) state_nxt = (in_data == 8'd0 || in_data > MAX_N) ? ERR : PAY;
         end
         PAY: begin
            if (fire) state_nxt = WHI;
         end
         WHI: state_nxt = WLO;
         WLO: begin
            if (k_inc < n_q)       state_nxt = PAY;
            else if (k_inc < HALF) state_nxt = PAD;
            else                   state_nxt = CHK;
         end
         PAD: begin
            // mem_addr is the word written this cycle; stop after the top word.
            if (mem_addr == LAST_ADDR) state_nxt = CHK;
         end
         CHK: begin
            if (fire) state_nxt = (in_data == sum_q) ? DONE : ERR;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is registered from the next state so it lines up with the state it describes.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
      if (!reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         wakeup    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         n_q       <= '0;
         k_q       <= '0;
         byte_q    <= '0;
         sum_q     <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == HDR) || (state_nxt == PAY) || (state_nxt == CHK);
         mem_we   <= (state_nxt == WHI) || (state_nxt == WLO) || (state_nxt == PAD);
         cpu_hold <= (state_nxt != DONE);
         done     <= (state_nxt == DONE);
         err      <= (state_nxt == ERR);
         wakeup   <= (state_nxt == DONE) && (state != DONE);

         if (state == HDR && fire) begin
            n_q   <= in_data[ADDR_W:0];
            k_q   <= '0;
            sum_q <= '0;
         end

         if (state == PAY && fire) begin
            byte_q    <= in_data;
            sum_q     <= sum_q ^ in_data;
            mem_addr  <= ADDR_W'({k_q, 1'b0});
            mem_wdata <= DATA_W'(in_data[7:4]);
         end

         if (state == WHI) begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= DATA_W'(byte_q[3:0]);
         end

         if (state == WLO) k_q <= k_q + ADDR_W'(1);

         // Padding continues from the last written word: even slots get SLEEP, odd slots 0.
         if (state_nxt == PAD) begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= mem_addr[0] ? SLEEP_OP : '0;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan plus random
// frames, checked against a frame-level model of the resulting memory image and status.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [3:0] mem_wdata;
   logic       cpu_hold;
   logic       wakeup;
   logic       done;
   logic       err;

   always #5 clk = ~clk;

   prog_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .wakeup   (wakeup),
      .done     (done),
      .err      (err)
   );

   int         checks = 0;
   int         errors = 0;
   logic [3:0] tb_mem[16];
   logic [3:0] exp_mem[16];
   int         wr_addr_q[$];
   int         wake_cnt = 0;
   int         overlap = 0;
   logic [7:0] frame[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Passive memory/pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         tb_mem[mem_addr] = mem_wdata;
         wr_addr_q.push_back(int'(mem_addr));
      end
      if (wakeup) wake_cnt++;
      if (mem_we && in_ready) overlap++;
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_ready", in_ready, 1);
      check("start_err", err, 0);
      check("start_done", done, 0);
      check("start_hold", cpu_hold, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         if (rnd && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = b;
         end
         if (rnd) start = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (!acc) check("accept_timeout", 32'(acc), 1);
   endtask

   task automatic run_frame(input bit rnd);
      int         n, wb, wk, ov, t;
      bit         hdr_ok, ok;
      logic [7:0] s;
      n      = int'(frame[0]);
      hdr_ok = (n >= 1) && (n <= 8);
      wb     = wr_addr_q.size();
      wk     = wake_cnt;
      ov     = overlap;
      pulse_start();
      send_byte(frame[0], rnd);
      if (!hdr_ok) check("hdr_err_now", err, 1);
      else for (int i = 1; i <= n + 1; i++) send_byte(frame[i], rnd);

      s  = 8'h00;
      ok = 1'b0;
      if (hdr_ok) begin
         for (int i = 1; i <= n; i++) s ^= frame[i];
         ok = (frame[n + 1] == s);
         for (int a = 0; a < 16; a++) begin
            if (a < 2 * n) exp_mem[a] = (a % 2 == 0) ? frame[1 + a / 2][7:4] : frame[1 + a / 2][3:0];
            else           exp_mem[a] = (a % 2 == 0) ? 4'h8 : 4'h0;
         end
      end

      t = 0;
      while (t < 100 && !(done || err)) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done", done, 32'(ok));
      check("err", err, 32'(!ok));
      check("cpu_hold", cpu_hold, 32'(!ok));
      check("wakeups", wake_cnt - wk, ok ? 1 : 0);
      check("writes", wr_addr_q.size() - wb, hdr_ok ? 16 : 0);
      check("ready_we_overlap", overlap - ov, 0);
      if (hdr_ok && wr_addr_q.size() - wb == 16)
         for (int j = 0; j < 16; j++) check($sformatf("wr_order%0d", j), wr_addr_q[wb + j], j);
      for (int a = 0; a < 16; a++) check($sformatf("mem%0d", a), tb_mem[a], exp_mem[a]);
   endtask

   task automatic check_image(input string tag, input logic [63:0] img);
      for (int a = 0; a < 16; a++)
         check($sformatf("%s_w%0d", tag, a), tb_mem[a], img[63 - 4 * a -: 4]);
   endtask

   initial begin
      int n;
      bit bad;
      for (int a = 0; a < 16; a++) exp_mem[a] = 4'h0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", in_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_hold", cpu_hold, 1);
      check("rst_wakeup", wakeup, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset = 1'b1;

      // Full program, back-to-back bytes.
      frame = '{8'h08, 8'h15, 8'h13, 8'h20, 8'h30, 8'h40, 8'h50, 8'h70, 8'h80, 8'hF6};
      run_frame(1'b0);
      check_image("full", 64'h1513_2030_4050_7080);

      // Short program with padding.
      frame = '{8'h02, 8'h15, 8'h13, 8'h06};
      run_frame(1'b0);
      check_image("short", 64'h1513_8080_8080_8080);

      // Bad checksum, then restart must clear err.
      frame = '{8'h02, 8'h15, 8'h13, 8'h07};
      run_frame(1'b0);

      // Bad headers: 0 and 9.
      frame = '{8'h00};
      run_frame(1'b0);
      frame = '{8'h09};
      run_frame(1'b0);

      // Short program under random gaps and ignored busy starts.
      frame = '{8'h02, 8'h15, 8'h13, 8'h06};
      run_frame(1'b1);
      check_image("gaps", 64'h1513_8080_8080_8080);

      // Reset after the third memory write of the full program.
      frame = '{8'h08, 8'h15, 8'h13, 8'h20, 8'h30, 8'h40, 8'h50, 8'h70, 8'h80, 8'hF6};
      n = wr_addr_q.size();
      pulse_start();
      send_byte(8'h08, 1'b0);
      send_byte(8'h15, 1'b0);
      send_byte(8'h13, 1'b0);
      @(negedge clk); #1;
      check("pre_rst_writes", wr_addr_q.size() - n, 3);
      reset = 1'b0;
      @(posedge clk); #1;
      check("mrst_ready", in_ready, 0);
      check("mrst_we", mem_we, 0);
      check("mrst_addr", mem_addr, 0);
      check("mrst_wdata", mem_wdata, 0);
      check("mrst_hold", cpu_hold, 1);
      check("mrst_wakeup", wakeup, 0);
      check("mrst_done", done, 0);
      check("mrst_err", err, 0);
      reset = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h02;
      n = wr_addr_q.size();
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      check("idle_writes", wr_addr_q.size() - n, 0);
      run_frame(1'b0);

      // Random frames: mostly valid, some bad headers or corrupted checksums.
      for (int f = 0; f < 20; f++) begin
         logic [7:0] s;
         frame.delete();
         if ($urandom_range(0, 5) == 0) begin
            frame.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(9, 255)));
         end else begin
            n = $urandom_range(1, 8);
            frame.push_back(8'(n));
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
               frame.push_back(8'($urandom));
               s ^= frame[i + 1];
            end
            bad = ($urandom_range(0, 3) == 0);
            frame.push_back(bad ? (s ^ 8'(1 << $urandom_range(0, 7))) : s);
         end
         run_frame(1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
